chan_sel_mux: RTL and testbench

Parametrised, registered N-channel W-bit selector with valid/ready flow control. It is the next generation of the processor's fixed 10:1 single-bit mux. It adds per-channel handshakes, a one-entry output register, a round-robin arbitration mode and out-of-range select detection. It sits between datapath producers (register read ports, ALU results, immediates) and a single consumer stage.

---
 rtl/chan_sel_mux_pkg.sv | 15 +
 rtl/chan_sel_mux_if.sv | 29 ++
 rtl/chan_sel_mux_rr_pick.sv | 31 +++
 rtl/chan_sel_mux.sv | 95 +++++++++
 tb/tb_chan_sel_mux.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/chan_sel_mux_pkg.sv
// Shared definitions for the channel selector: mode encoding and the
// helper that locates a channel's slice inside the flat in_data bus.
package chan_sel_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // LSB position of channel k within the concatenated in_data vector.
    function automatic int unsigned ch_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/chan_sel_mux_if.sv
// Producer/consumer bundle for chan_sel_mux. The slave modport is the
// mux side; the master modport drives the channels and the consumer ready.
interface chan_sel_mux_if #(
    parameter int NUM_CH = 10,
    parameter int WIDTH  = 8
);
    localparam int SEL_W = $clog2(NUM_CH);

    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_ch;
    logic                    out_valid;
    logic                    out_ready;
    logic                    err_sel;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid, err_sel
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid, err_sel
    );
endinterface

// File: rtl/chan_sel_mux_rr_pick.sv
// Combinational round-robin search: first requester after ptr, wrapping
// modulo NUM_CH, with ptr itself considered last.
module rr_pick
    import chan_sel_pkg::*;
#(
    parameter int NUM_CH = 10,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [SEL_W-1:0]  i_ptr,
    output logic [SEL_W-1:0]  o_grant,
    output logic              o_grant_valid
);

    int w_idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_grant       = '0;
        o_grant_valid = 1'b0;
        w_idx         = 0;
        for (int i = NUM_CH; i >= 1; i--) begin
            w_idx = (int'(i_ptr) + i) % NUM_CH;
            if (i_req[w_idx]) begin
                o_grant       = SEL_W'(w_idx);
                o_grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chan_sel_mux.sv
// Registered N:1 channel selector with valid/ready handshakes, fixed or
// round-robin selection, and a registered flag for out-of-range selects.
module chan_sel_mux
    import chan_sel_pkg::*;
#(
    parameter int NUM_CH = 10,
    parameter int WIDTH  = 8,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic           clk,
    input  logic           rst,
    chan_sel_mux_if.slave  bus
);

    localparam logic [SEL_W:0]   NUM_CH_L = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] PTR_RST  = SEL_W'(NUM_CH - 1);

    logic [WIDTH-1:0]  r_out_data;
    logic [SEL_W-1:0]  r_out_ch;
    logic              r_out_valid;
    logic              r_err_sel;
    logic [SEL_W-1:0]  r_ptr;

    logic              w_free;
    logic              w_sel_ok;
    logic              w_sel_bad;
    logic [SEL_W-1:0]  w_rr_grant;
    logic              w_rr_valid;
    logic [SEL_W-1:0]  w_cand;
    logic              w_cand_ok;
    logic              w_accept;
    logic [NUM_CH-1:0] w_in_ready;
    logic [WIDTH-1:0]  w_cand_data;

    rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
        .i_req         (bus.in_valid),
        .i_ptr         (r_ptr),
        .o_grant       (w_rr_grant),
        .o_grant_valid (w_rr_valid)
    );

    assign w_free    = !r_out_valid || bus.out_ready;
    assign w_sel_ok  = {1'b0, bus.sel} < NUM_CH_L;
    assign w_sel_bad = (bus.mode == MODE_FIXED) && !w_sel_ok;

    always_comb begin
        w_cand    = '0;
        w_cand_ok = 1'b0;
        if (bus.mode == MODE_RR) begin
            w_cand    = w_rr_grant;
            w_cand_ok = w_rr_valid;
        end else if (w_sel_ok) begin
            w_cand    = bus.sel;
            w_cand_ok = 1'b1;
        end
    end

    // w_cand is forced to 0 when there is no candidate, so the slice stays in range.
    assign w_cand_data = bus.in_data[ch_lsb(32'(w_cand), WIDTH) +: WIDTH];
    assign w_accept    = !rst && w_free && w_cand_ok && bus.in_valid[w_cand];

    always_comb begin
        w_in_ready = '0;
        if (!rst && w_free && w_cand_ok)
            w_in_ready[w_cand] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_err_sel   <= 1'b0;
            r_ptr       <= PTR_RST;
        end else begin
            r_err_sel <= w_sel_bad;
            if (w_accept) begin
                r_out_data  <= w_cand_data;
                r_out_ch    <= w_cand;
                r_out_valid <= 1'b1;
                if (bus.mode == MODE_RR)
                    r_ptr <= w_cand;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_valid = r_out_valid;
    assign bus.err_sel   = r_err_sel;

endmodule

// File: tb/tb_chan_sel_mux.sv
// Directed scenarios followed by randomized traffic, all checked against a
// cycle-level behavioural model of the selector kept in the bench.
module tb_chan_sel_mux;
    import chan_sel_pkg::*;

    localparam int N = 10;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    chan_sel_mux_if #(.NUM_CH(N), .WIDTH(W)) bus ();

    chan_sel_mux #(.NUM_CH(N), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] d [N];
    logic [N-1:0] obs_rdy;

    // Model state
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_ch;
    int           m_ptr;
    bit           m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        for (int k = 0; k < N; k++) bus.in_data[k*W +: W] = d[k];
    endtask

    task automatic model_reset();
        m_valid = 0; m_data = '0; m_ch = 0; m_ptr = N - 1; m_err = 0;
    endtask

    // One clock: check in_ready mid-cycle, advance model, check registers.
    task automatic cycle();
        int  c;
        bit  free, acc;
        logic [N-1:0] exp_rdy;
        drive_data();
        @(negedge clk);
        free = !m_valid || bus.out_ready;
        c = -1;
        if (bus.mode == MODE_FIXED) begin
            if (int'(bus.sel) < N) c = int'(bus.sel);
        end else begin
            for (int o = 1; o <= N; o++) begin
                if (bus.in_valid[(m_ptr + o) % N]) begin
                    c = (m_ptr + o) % N;
                    break;
                end
            end
        end
        exp_rdy = '0;
        if (!rst && free && c >= 0) exp_rdy[c] = 1'b1;
        obs_rdy = bus.in_ready;
        chk("in_ready", 64'(obs_rdy), 64'(exp_rdy));
        acc = !rst && free && (c >= 0) && bus.in_valid[c];
        if (rst) begin
            model_reset();
        end else begin
            m_err = (bus.mode == MODE_FIXED) && (int'(bus.sel) >= N);
            if (acc) begin
                m_data = d[c]; m_ch = c; m_valid = 1;
                if (bus.mode == MODE_RR) m_ptr = c;
            end else if (m_valid && bus.out_ready) begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
        chk("out_data",  64'(bus.out_data),  64'(m_data));
        chk("out_ch",    64'(bus.out_ch),    64'(m_ch));
        chk("err_sel",   64'(bus.err_sel),   64'(m_err));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = '0;
        bus.mode      = MODE_FIXED;
        bus.sel       = '0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < N; k++) d[k] = W'(8'h10 + k);
        drive_data();
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        chk("reset_out_valid", 64'(bus.out_valid), 64'(0));
        chk("reset_out_data", 64'(bus.out_data), 64'(0));

        // Fixed select of channel 3 with everyone valid
        bus.mode = MODE_FIXED; bus.sel = 4'd3; bus.in_valid = '1; bus.out_ready = 1'b1;
        cycle();
        chk("fixed_rdy", 64'(obs_rdy), 64'h008);
        chk("fixed_data", 64'(bus.out_data), 64'h13);
        chk("fixed_ch", 64'(bus.out_ch), 64'd3);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("fixed_stream_valid", 64'(bus.out_valid), 64'd1);
        end

        // Round-robin fairness from reset, including wrap 9 -> 0
        do_reset();
        bus.mode = MODE_RR; bus.in_valid = '1; bus.out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            cycle();
            chk("rr_seq", 64'(bus.out_ch), 64'(i % N));
        end

        // Backpressure: output holds channel 0, channel 5 waits
        bus.out_ready = 1'b0; bus.in_valid = 10'h020;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("bp_rdy", 64'(obs_rdy), 64'd0);
            chk("bp_ch_hold", 64'(bus.out_ch), 64'd0);
        end
        bus.out_ready = 1'b1;
        cycle();
        chk("bp_release_ch", 64'(bus.out_ch), 64'd5);
        chk("bp_release_data", 64'(bus.out_data), 64'h15);

        // Invalid select, then recovery
        bus.mode = MODE_FIXED; bus.sel = 4'd12; bus.in_valid = '1;
        cycle();
        chk("bad_sel_rdy", 64'(obs_rdy), 64'd0);
        chk("bad_sel_err", 64'(bus.err_sel), 64'd1);
        chk("bad_sel_drain", 64'(bus.out_valid), 64'd0);
        bus.sel = 4'd2;
        cycle();
        chk("sel_ok_err", 64'(bus.err_sel), 64'd0);
        chk("sel_ok_ch", 64'(bus.out_ch), 64'd2);

        // Mode switch keeps ptr from the last RR grant
        do_reset();
        bus.mode = MODE_RR; bus.in_valid = 10'h010;
        cycle();
        chk("ms_rr4", 64'(bus.out_ch), 64'd4);
        bus.mode = MODE_FIXED; bus.sel = 4'd7; bus.in_valid = 10'h080;
        cycle();
        chk("ms_fixed7", 64'(bus.out_ch), 64'd7);
        bus.mode = MODE_RR; bus.in_valid = '1;
        cycle();
        chk("ms_rr_next", 64'(bus.out_ch), 64'd5);

        // Reset while holding data
        rst = 1'b1;
        cycle();
        chk("midrst_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_rdy", 64'(obs_rdy), 64'd0);
        rst = 1'b0;
        cycle();
        chk("midrst_first", 64'(bus.out_ch), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(0, 49) == 0);
            bus.mode      = ($urandom_range(0, 2) != 0) ? MODE_RR : MODE_FIXED;
            bus.sel       = 4'($urandom_range(0, 15));
            bus.in_valid  = N'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) d[k] = W'($urandom);
            cycle();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
